// File: rtl/sdr_app_bram_resp.sv
// sdr_app_bram_resp: BRAM-backed SDRAM app-port responder with init, refresh and fixed read latency.
// Optional SDR_RESP_DROP_FLAG_EN adds a sticky req_drop output for ignored requests.
module sdr_app_bram_resp #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 32,
  parameter int DEPTH_W     = 12,
  parameter int INIT_CYCLES = 100,
  parameter int REF_PERIOD  = 780,
  parameter int REF_CYCLES  = 8,
  parameter int RD_LAT      = 2
) (
  input  logic                mem_clk,
  input  logic                rst,
  input  logic                App_wr_en,
  input  logic [ADDR_W-1:0]   App_wr_addr,
  input  logic [DATA_W-1:0]   App_wr_din,
  input  logic [DATA_W/8-1:0] App_wr_dm,
  input  logic                App_rd_en,
  input  logic [ADDR_W-1:0]   App_rd_addr,
  output logic                Sdr_init_done,
  output logic                Sdr_init_ref_vld,
  output logic                Sdr_busy,
  output logic                Sdr_rd_en,
  output logic [DATA_W-1:0]   Sdr_rd_dout
`ifdef SDR_RESP_DROP_FLAG_EN
  ,
  output logic                req_drop
`endif
);
  localparam int CNT_MAX = (INIT_CYCLES > REF_CYCLES) ?
                           ((INIT_CYCLES > RD_LAT) ? INIT_CYCLES : RD_LAT) :
                           ((REF_CYCLES > RD_LAT) ? REF_CYCLES : RD_LAT);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int REF_W = $clog2(REF_PERIOD + 1);
  localparam int NB    = DATA_W / 8;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WRITE, S_READ, S_REFRESH} state_t;
  state_t               r_state, w_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [REF_W-1:0]     r_ref_cnt;
  logic                 r_pend;
  logic                 r_init_done;
  logic                 r_ref_vld;
  logic                 r_busy;
  logic                 r_rd_en;
  logic [DATA_W-1:0]    r_rd_dout;
  logic [DEPTH_W-1:0]   r_raddr;
  logic [DATA_W-1:0]    r_mem [2**DEPTH_W];
  logic                 w_ok;
  logic                 w_acc_wr;
  logic                 w_acc_rd;
  logic                 w_wrap;
  logic                 w_rd_fire;
  logic [DEPTH_W-1:0]   w_waddr;
  logic [DEPTH_W-1:0]   w_ridx;
  logic                 w_unused;
  assign w_unused  = ^{App_wr_addr[ADDR_W-1:DEPTH_W], App_rd_addr[ADDR_W-1:DEPTH_W]};
  assign w_ok      = (r_state == S_IDLE) && !r_busy && !r_pend && !rst;
  assign w_acc_wr  = w_ok && App_wr_en;
  assign w_acc_rd  = w_ok && !App_wr_en && App_rd_en;
  assign w_wrap    = r_init_done && (r_ref_cnt == REF_W'(REF_PERIOD - 1));
  assign w_waddr   = App_wr_addr[DEPTH_W-1:0];
  // With RD_LAT==1 the data leaves on the accept edge, before the address register is loaded.
  assign w_rd_fire = (RD_LAT == 1) ? w_acc_rd :
                     (r_state == S_READ) && (r_cnt == CNT_W'(RD_LAT - 2));
  assign w_ridx    = (RD_LAT == 1) ? App_rd_addr[DEPTH_W-1:0] : r_raddr;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_INIT:    w_nxt = (r_cnt == CNT_W'(INIT_CYCLES - 1)) ? S_IDLE : S_INIT;
      S_IDLE:    w_nxt = r_pend ? S_REFRESH : w_acc_wr ? S_WRITE : w_acc_rd ? S_READ : S_IDLE;
      S_WRITE:   w_nxt = S_IDLE;
      S_READ:    w_nxt = (r_cnt == CNT_W'(RD_LAT - 1)) ? S_IDLE : S_READ;
      S_REFRESH: w_nxt = (r_cnt == CNT_W'(REF_CYCLES - 1)) ? S_IDLE : S_REFRESH;
      default:   w_nxt = S_INIT;
    endcase
  end
  always_ff @(posedge mem_clk) begin
    if (w_acc_wr)
      for (int b = 0; b < NB; b++)
        if (!App_wr_dm[b]) r_mem[w_waddr][8*b +: 8] <= App_wr_din[8*b +: 8];
    if (w_acc_rd) r_raddr <= App_rd_addr[DEPTH_W-1:0];
  end
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_ref_cnt   <= '0;
      r_pend      <= 1'b0;
      r_init_done <= 1'b0;
      r_ref_vld   <= 1'b1;
      r_busy      <= 1'b1;
      r_rd_en     <= 1'b0;
      r_rd_dout   <= '0;
    end else begin
      r_state     <= w_nxt;
      r_cnt       <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_ref_cnt   <= (!r_init_done || w_wrap) ? '0 : r_ref_cnt + 1'b1;
      r_pend      <= w_wrap || (r_pend && r_state != S_IDLE);
      r_init_done <= r_init_done || (w_nxt != S_INIT);
      r_ref_vld   <= (w_nxt == S_INIT) || (w_nxt == S_REFRESH);
      r_busy      <= w_nxt != S_IDLE;
      r_rd_en     <= w_rd_fire;
      if (w_rd_fire) r_rd_dout <= r_mem[w_ridx];
    end
  end
  assign Sdr_init_done    = r_init_done;
  assign Sdr_init_ref_vld = r_ref_vld;
  assign Sdr_busy         = r_busy;
  assign Sdr_rd_en        = r_rd_en;
  assign Sdr_rd_dout      = r_rd_dout;
`ifdef SDR_RESP_DROP_FLAG_EN
  logic r_drop;
  logic w_ign;
  // A read that loses to a simultaneous write counts as ignored.
  assign w_ign = ((App_wr_en || App_rd_en) && !(w_acc_wr || w_acc_rd)) || (w_acc_wr && App_rd_en);
  always_ff @(posedge mem_clk) begin
    if (rst) r_drop <= 1'b0;
    else     r_drop <= r_drop || w_ign;
  end
  assign req_drop = r_drop;
`endif
endmodule

// File: tb/tb_sdr_app_bram_resp.sv
// tb_sdr_app_bram_resp: directed self-checking bench for sdr_app_bram_resp.
module tb_sdr_app_bram_resp;
  logic        mem_clk = 1'b0;
  logic        rst = 1'b1;
  logic        App_wr_en = 1'b0;
  logic [20:0] App_wr_addr = '0;
  logic [31:0] App_wr_din = '0;
  logic [3:0]  App_wr_dm = '0;
  logic        App_rd_en = 1'b0;
  logic [20:0] App_rd_addr = '0;
  logic        Sdr_init_done, Sdr_init_ref_vld, Sdr_busy, Sdr_rd_en;
  logic [31:0] Sdr_rd_dout;
`ifdef SDR_RESP_DROP_FLAG_EN
  logic        req_drop;
`endif
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  sdr_app_bram_resp dut (
    .mem_clk(mem_clk), .rst(rst),
    .App_wr_en(App_wr_en), .App_wr_addr(App_wr_addr), .App_wr_din(App_wr_din), .App_wr_dm(App_wr_dm),
    .App_rd_en(App_rd_en), .App_rd_addr(App_rd_addr),
    .Sdr_init_done(Sdr_init_done), .Sdr_init_ref_vld(Sdr_init_ref_vld), .Sdr_busy(Sdr_busy),
    .Sdr_rd_en(Sdr_rd_en), .Sdr_rd_dout(Sdr_rd_dout)
`ifdef SDR_RESP_DROP_FLAG_EN
    , .req_drop(req_drop)
`endif
  );

  always #5 mem_clk = ~mem_clk;

  task automatic tick;
    @(posedge mem_clk);
    @(negedge mem_clk);
    cyc++;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [31:0] d, input logic [3:0] m);
    App_wr_en = 1'b1; App_wr_addr = a; App_wr_din = d; App_wr_dm = m;
    tick;
    App_wr_en = 1'b0;
    tick;
  endtask

  // Read accepted in the current cycle T; returns observations for T+1..T+3.
  task automatic do_read(input logic [20:0] a, output logic b1, output logic e1,
                         output logic b2, output logic e2, output logic [31:0] d2,
                         output logic b3, output logic e3, output logic [31:0] d3);
    App_rd_en = 1'b1; App_rd_addr = a;
    tick;
    App_rd_en = 1'b0;
    b1 = Sdr_busy; e1 = Sdr_rd_en;
    tick;
    b2 = Sdr_busy; e2 = Sdr_rd_en; d2 = Sdr_rd_dout;
    tick;
    b3 = Sdr_busy; e3 = Sdr_rd_en; d3 = Sdr_rd_dout;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if (Sdr_init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done got=%b exp=0", Sdr_init_done); end
    checks++; if (Sdr_init_ref_vld !== 1'b1) begin failures++; $display("FAIL rst_ref_vld got=%b exp=1", Sdr_init_ref_vld); end
    checks++; if (Sdr_busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", Sdr_busy); end
    checks++; if (Sdr_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", Sdr_rd_en); end
    checks++; if (Sdr_rd_dout !== 32'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0", Sdr_rd_dout); end
`ifdef SDR_RESP_DROP_FLAG_EN
    checks++; if (req_drop !== 1'b0) begin failures++; $display("FAIL rst_drop got=%b exp=0", req_drop); end
`endif
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_init;
    repeat (99) tick;
    checks++; if ({Sdr_init_done, Sdr_busy, Sdr_init_ref_vld} !== 3'b011) begin failures++; $display("FAIL init_c99 got=%b exp=011", {Sdr_init_done, Sdr_busy, Sdr_init_ref_vld}); end
    tick;
    checks++; if ({Sdr_init_done, Sdr_busy, Sdr_init_ref_vld} !== 3'b100) begin failures++; $display("FAIL init_c100 got=%b exp=100", {Sdr_init_done, Sdr_busy, Sdr_init_ref_vld}); end
  endtask

  task automatic test_write_read;
    logic b1, e1, b2, e2, b3, e3;
    logic [31:0] d2, d3;
    App_wr_en = 1'b1; App_wr_addr = 21'h00005; App_wr_din = 32'hA5A5_1234; App_wr_dm = 4'h0;
    tick;
    App_wr_en = 1'b0;
    checks++; if (Sdr_busy !== 1'b1) begin failures++; $display("FAIL wr_busy_t1 got=%b exp=1", Sdr_busy); end
    tick;
    checks++; if (Sdr_busy !== 1'b0) begin failures++; $display("FAIL wr_busy_t2 got=%b exp=0", Sdr_busy); end
    do_read(21'h00005, b1, e1, b2, e2, d2, b3, e3, d3);
    checks++; if ({b1, e1} !== 2'b10) begin failures++; $display("FAIL rd_t1 busy,en got=%b exp=10", {b1, e1}); end
    checks++; if ({b2, e2} !== 2'b11) begin failures++; $display("FAIL rd_t2 busy,en got=%b exp=11", {b2, e2}); end
    checks++; if (d2 !== 32'hA5A5_1234) begin failures++; $display("FAIL rd_t2_data got=%h exp=a5a51234", d2); end
    checks++; if ({b3, e3} !== 2'b00) begin failures++; $display("FAIL rd_t3 busy,en got=%b exp=00", {b3, e3}); end
    checks++; if (d3 !== 32'hA5A5_1234) begin failures++; $display("FAIL rd_dout_hold got=%h exp=a5a51234", d3); end
  endtask

  task automatic test_byte_mask;
    logic b1, e1, b2, e2, b3, e3;
    logic [31:0] d2, d3;
    do_write(21'h00005, 32'hFFFF_FFFF, 4'b0101);
    do_read(21'h00005, b1, e1, b2, e2, d2, b3, e3, d3);
    checks++; if (e2 !== 1'b1 || d2 !== 32'hFFA5_FF34) begin failures++; $display("FAIL byte_mask en=%b data=%h exp en=1 data=ffa5ff34", e2, d2); end
  endtask

  task automatic test_collision_alias;
    logic b1, e1, b2, e2, b3, e3;
    logic [31:0] d2, d3;
    int pulses;
`ifdef SDR_RESP_DROP_FLAG_EN
    checks++; if (req_drop !== 1'b0) begin failures++; $display("FAIL drop_before got=%b exp=0", req_drop); end
`endif
    App_wr_en = 1'b1; App_wr_addr = 21'h01005; App_wr_din = 32'hDEAD_BEEF; App_wr_dm = 4'h0;
    App_rd_en = 1'b1; App_rd_addr = 21'h00009;
    tick;
    App_wr_en = 1'b0; App_rd_en = 1'b0;
    checks++; if (Sdr_busy !== 1'b1) begin failures++; $display("FAIL coll_busy got=%b exp=1", Sdr_busy); end
`ifdef SDR_RESP_DROP_FLAG_EN
    checks++; if (req_drop !== 1'b1) begin failures++; $display("FAIL coll_drop got=%b exp=1", req_drop); end
`endif
    pulses = int'(Sdr_rd_en);
    repeat (3) begin tick; pulses += int'(Sdr_rd_en); end
    checks++; if (pulses != 0) begin failures++; $display("FAIL coll_no_read pulses=%0d exp=0", pulses); end
    do_read(21'h00005, b1, e1, b2, e2, d2, b3, e3, d3);
    checks++; if (e2 !== 1'b1 || d2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alias en=%b data=%h exp en=1 data=deadbeef", e2, d2); end
  endtask

  task automatic test_refresh;
    int bad;
    while (cyc < 880) tick;
    checks++; if ({Sdr_busy, Sdr_init_ref_vld} !== 2'b00) begin failures++; $display("FAIL ref_c880 busy,vld got=%b exp=00", {Sdr_busy, Sdr_init_ref_vld}); end
    App_rd_en = 1'b1; App_rd_addr = 21'h00005;
    bad = 0;
    repeat (8) begin
      tick;
      if ({Sdr_busy, Sdr_init_ref_vld, Sdr_rd_en} !== 3'b110) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL ref_window bad_cycles=%0d exp=0", bad); end
    tick;
    checks++; if ({Sdr_busy, Sdr_init_ref_vld} !== 2'b00) begin failures++; $display("FAIL ref_end busy,vld got=%b exp=00", {Sdr_busy, Sdr_init_ref_vld}); end
    tick;
    App_rd_en = 1'b0;
    checks++; if ({Sdr_busy, Sdr_rd_en} !== 2'b10) begin failures++; $display("FAIL ref_rd_t1 busy,en got=%b exp=10", {Sdr_busy, Sdr_rd_en}); end
    tick;
    checks++; if (Sdr_rd_en !== 1'b1 || Sdr_rd_dout !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ref_rd_t2 en=%b data=%h exp en=1 data=deadbeef", Sdr_rd_en, Sdr_rd_dout); end
    tick;
    checks++; if (Sdr_rd_en !== 1'b0) begin failures++; $display("FAIL ref_rd_t3 en=%b exp=0", Sdr_rd_en); end
  endtask

  task automatic test_reset_mid_read;
    logic b1, e1, b2, e2, b3, e3;
    logic [31:0] d2, d3;
    int pulses;
    App_rd_en = 1'b1; App_rd_addr = 21'h00005;
    tick;
    App_rd_en = 1'b0;
    rst = 1'b1;
    tick;
    checks++; if ({Sdr_rd_en, Sdr_busy, Sdr_init_done, Sdr_init_ref_vld} !== 4'b0101) begin failures++; $display("FAIL midrst_outs en,busy,done,vld got=%b exp=0101", {Sdr_rd_en, Sdr_busy, Sdr_init_done, Sdr_init_ref_vld}); end
    checks++; if (Sdr_rd_dout !== 32'h0) begin failures++; $display("FAIL midrst_dout got=%h exp=0", Sdr_rd_dout); end
`ifdef SDR_RESP_DROP_FLAG_EN
    checks++; if (req_drop !== 1'b0) begin failures++; $display("FAIL midrst_drop got=%b exp=0", req_drop); end
`endif
    rst = 1'b0;
    cyc = 0;
    pulses = 0;
    repeat (99) begin tick; pulses += int'(Sdr_rd_en); end
    checks++; if (Sdr_init_done !== 1'b0) begin failures++; $display("FAIL reinit_c99 done=%b exp=0", Sdr_init_done); end
    tick;
    pulses += int'(Sdr_rd_en);
    checks++; if ({Sdr_init_done, Sdr_busy} !== 2'b10) begin failures++; $display("FAIL reinit_c100 done,busy got=%b exp=10", {Sdr_init_done, Sdr_busy}); end
    checks++; if (pulses != 0) begin failures++; $display("FAIL midrst_no_pulse pulses=%0d exp=0", pulses); end
    do_read(21'h00005, b1, e1, b2, e2, d2, b3, e3, d3);
    checks++; if (e2 !== 1'b1 || d2 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mem_persist en=%b data=%h exp en=1 data=deadbeef", e2, d2); end
  endtask

  initial begin
    @(negedge mem_clk);
    test_reset;
    test_init;
    test_write_read;
    test_byte_mask;
    test_collision_alias;
    test_refresh;
    test_reset_mid_read;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdr_app_bram_resp.md
Name: sdr_app_bram_resp

Overview:
- Responder (memory side) of the SDRAM application port driven by the frame read/write engine.
- Accepts App_wr_en/App_rd_en requests and services them from an on-chip block-RAM backing store.
- Generates Sdr_init_done, Sdr_init_ref_vld, Sdr_busy and the Sdr_rd_en/Sdr_rd_dout return path with SDRAM-like timing: init window, periodic refresh, fixed read latency.
- Used for simulation and as a BRAM fallback in place of the external SDRAM controller.

Parameters:
- ADDR_W, 21, width of App_rd_addr and App_wr_addr.
- DATA_W, 32, data word width; must be a multiple of 8.
- DEPTH_W, 12, log2 of backing-store depth in words; only addr[DEPTH_W-1:0] is used.
- INIT_CYCLES, 100, length of the post-reset init window in cycles; must be >= 1.
- REF_PERIOD, 780, cycles between refresh requests.
- REF_CYCLES, 8, length of each refresh window in cycles.
- RD_LAT, 2, cycles from read accept to data valid; must be >= 1.

Ports:
- mem_clk  in  1  memory clock, sole clock.
- rst  in  1  synchronous reset, active-high.
- App_wr_en  in  1  write request.
- App_wr_addr  in  ADDR_W  write word address.
- App_wr_din  in  DATA_W  write data.
- App_wr_dm  in  DATA_W/8  byte mask; bit=1 means that byte is NOT written.
- App_rd_en  in  1  read request.
- App_rd_addr  in  ADDR_W  read word address.
- Sdr_init_done  out  1  high once the init window has ended; stays high until rst.
- Sdr_init_ref_vld  out  1  high during init and during refresh.
- Sdr_busy  out  1  responder cannot accept a request this cycle.
- Sdr_rd_en  out  1  one-cycle pulse; Sdr_rd_dout valid in the same cycle.
- Sdr_rd_dout  out  DATA_W  read data.

Behaviour:
- Interface: one clock (mem_clk). Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - Sdr_init_done=0, Sdr_init_ref_vld=1, Sdr_busy=1, Sdr_rd_en=0, Sdr_rd_dout=0.
  - State=INIT, refresh counter=0, refresh pending=0.
  - Memory contents are not reset.
- FSM states: INIT, IDLE, WRITE, READ, REFRESH.
- INIT:
  - Counts INIT_CYCLES cycles with busy=1 and ref_vld=1.
  - Then goes to IDLE; in the same edge init_done=1, busy=0, ref_vld=0.
- Refresh counter:
  - Free-runs from the first IDLE cycle and wraps at REF_PERIOD-1.
  - Each wrap sets the sticky pending flag. A second wrap while the flag is still set is absorbed (single flag, no queueing).
- Accept rule: a request is accepted only in a cycle where state==IDLE, Sdr_busy==0 and pending==0. Requests in any other cycle are ignored, not queued; the initiator must hold or retry.
- Priority in IDLE: pending refresh > write > read.
  - If App_wr_en and App_rd_en are both high, the write is accepted and the read is ignored.
- IDLE with pending set:
  - Go to REFRESH and clear pending.
  - busy=1 and ref_vld=1 for exactly REF_CYCLES cycles, then IDLE.
- Write accepted at cycle T:
  - Unmasked bytes are stored at edge T.
  - busy=1 in cycle T+1 only (WRITE state), then IDLE.
- Read accepted at cycle T:
  - Address captured at T.
  - busy=1 for cycles T+1..T+RD_LAT.
  - Sdr_rd_en=1 and Sdr_rd_dout valid in cycle T+RD_LAT.
  - Earliest next accept is T+RD_LAT+1.
  - Sdr_rd_dout holds its last value when Sdr_rd_en=0.
- Read after write to the same address returns the new data. Serialization guarantees this; no bypass is needed.
- Address bits above DEPTH_W-1 are ignored, so addresses alias modulo 2^DEPTH_W.
- rst asserted mid-operation:
  - Any in-flight read is aborted and Sdr_rd_en is never pulsed for it.
  - A write already committed at its accept edge persists.
  - The block restarts from INIT.

Optional Feature:
- Macro: SDR_RESP_DROP_FLAG_EN.
- Defined: adds output req_drop (1 bit, reset 0), a sticky flag set on the cycle after any App_wr_en/App_rd_en is ignored. Ignored means busy, pending refresh, or a read losing to a simultaneous write. Cleared only by rst.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Init: release rst at cycle 0, hold requests low -> init_done rises and busy falls at cycle 100, ref_vld low from cycle 100.
- Write/read: write addr 0x00005, din 0xA5A5_1234, dm 0 -> read 0x00005 accepted at T gives Sdr_rd_en=1 and dout 0xA5A5_1234 exactly at T+2, busy high T+1..T+2.
- Byte mask: after the previous step, write 0x00005 din 0xFFFF_FFFF dm 4'b0101 -> read returns 0xFFA5_FF34.
- Refresh: idle 780 cycles after init -> busy and ref_vld high for 8 cycles. A read held high throughout is accepted on the first cycle after refresh ends and returns valid data RD_LAT later.
- Collision and alias: App_wr_en and App_rd_en high together in IDLE -> only the write executes, no Sdr_rd_en, req_drop=1 if enabled. Write 0x01005 then read 0x00005 -> same data.
- Reset mid-read: assert rst at T+1 after a read accept -> no Sdr_rd_en pulse, outputs return to reset values, init window restarts.
